soi_capture_sched: RTL

Capture scheduler for signal-of-interest (SOI) observation: accepts single-cycle capture strobes from up to NUM_CH probe points, holds one pending sample per channel, and shares a single record FIFO between channels with round-robin arbitration. The host side (DPI-exported reader) drains records through a valid/ready port. Sits between instrumented RTL (per-signal probes) and the simulator-facing readout.

---
 rtl/soi_obs_pkg.sv | 39 +++
 rtl/soi_rec_fifo.sv | 56 +++++
 rtl/soi_capture_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/soi_obs_pkg.sv
// rtl/soi_obs_pkg.sv - shared types, constants and round-robin pick helper for the SOI capture scheduler
// Contents: soi_rec_t record layout (ch, data, ts), DROP_W drop-counter width, MAX_CH channel ceiling,
//           rr_pick() first-set-at-or-after-pointer search.
package soi_obs_pkg;

  localparam int DROP_W = 8;
  localparam int MAX_CH = 16;

  // Record layout at its widest; instances use only the low bits of each field.
  typedef struct packed {
    logic [3:0]  ch;
    logic [31:0] data;
    logic [31:0] ts;
  } soi_rec_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of pend at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] pend,
                                       input logic [3:0]        ptr,
                                       input int                n);
    rr_pick_t r;
    int       idx;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !r.found && pend[idx]) begin
        r.found = 1'b1;
        r.idx   = idx[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/soi_rec_fifo.sv
// rtl/soi_rec_fifo.sv - synchronous record FIFO with full/empty/level
// Ports: i_clk, i_rst_n (async, active low), i_push/i_wdata write side, i_pop read side,
//        o_rdata head word (zero while empty), o_full, o_empty, o_level records held.
module soi_rec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  // Head is forced to zero when empty so the record outputs read 0 out of reset.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/soi_capture_sched.sv
// rtl/soi_capture_sched.sv - SOI capture scheduler: per-channel hold, round-robin grant into a shared record FIFO
// Ports: i_clk, i_rst_n (async, active low), i_enable strobe gate, i_ch_stb/i_ch_data probe inputs,
//        o_rec_valid/i_rec_ready/o_rec_ch/o_rec_data host record port, o_rec_ts (SOI_TIMESTAMP_EN only),
//        o_fifo_level, i_drop_clr/o_drop_cnt saturating drop counter.
// Optional feature macro: SOI_TIMESTAMP_EN adds a free-running timestamp sampled at strobe time.
module soi_capture_sched
  import soi_obs_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic [NUM_CH-1:0]          i_ch_stb,
  input  logic [NUM_CH*DATA_W-1:0]   i_ch_data,
  output logic                       o_rec_valid,
  input  logic                       i_rec_ready,
  output logic [$clog2(NUM_CH)-1:0]  o_rec_ch,
  output logic [DATA_W-1:0]          o_rec_data,
`ifdef SOI_TIMESTAMP_EN
  output logic [TS_W-1:0]            o_rec_ts,
`endif
  output logic [$clog2(DEPTH):0]     o_fifo_level,
  input  logic                       i_drop_clr,
  output logic [DROP_W-1:0]          o_drop_cnt
);

  localparam int CH_W = $clog2(NUM_CH);
`ifdef SOI_TIMESTAMP_EN
  localparam int TS_ON = 1;
`else
  localparam int TS_ON = 0;
`endif
  localparam int TS_BITS = TS_W * TS_ON;
  localparam int REC_W   = TS_BITS + CH_W + DATA_W;

  logic [NUM_CH-1:0] r_pend;
  logic [DATA_W-1:0] r_hold [NUM_CH];
  logic [CH_W-1:0]   r_rr_ptr;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_can_push;
  logic [MAX_CH-1:0] w_pend16;
  logic [3:0]        w_ptr4;
  rr_pick_t          w_pick;
  logic              w_grant;
  logic [CH_W-1:0]   w_gnt_ch;
  logic [CH_W-1:0]   w_rr_next;
  logic [NUM_CH-1:0] w_gnt_vec;
  logic [NUM_CH-1:0] w_stb_ok;
  logic [NUM_CH-1:0] w_drop_vec;
  logic [NUM_CH-1:0] w_accept;
  logic [4:0]        w_drop_n;
  logic [DROP_W-1:0] w_drop_base;
  logic [DROP_W:0]   w_drop_sum;
  logic [DROP_W-1:0] w_drop_next;
  logic [REC_W-1:0]  w_push_word;
  logic [REC_W-1:0]  w_head_word;

`ifdef SOI_TIMESTAMP_EN
  logic [TS_W-1:0]   r_ts;
  logic [TS_W-1:0]   r_ts_hold [NUM_CH];
`endif

  // A full FIFO can still take a record when the host pops in the same cycle.
  assign w_pop      = o_rec_valid & i_rec_ready;
  assign w_can_push = ~w_full | w_pop;

  always_comb begin
    w_pend16               = '0;
    w_pend16[NUM_CH-1:0]   = r_pend;
    w_ptr4                 = '0;
    w_ptr4[CH_W-1:0]       = r_rr_ptr;
    w_pick                 = rr_pick(w_pend16, w_ptr4, NUM_CH);
  end

  assign w_grant   = w_pick.found & w_can_push;
  assign w_gnt_ch  = CH_W'(w_pick.idx);
  assign w_rr_next = (w_gnt_ch == CH_W'(NUM_CH-1)) ? '0 : w_gnt_ch + CH_W'(1);

  always_comb begin
    w_gnt_vec = '0;
    if (w_grant) w_gnt_vec[w_gnt_ch] = 1'b1;
  end

  // A strobe on the channel being granted this cycle refills the hold and is not a drop.
  assign w_stb_ok   = i_ch_stb & {NUM_CH{i_enable}};
  assign w_drop_vec = w_stb_ok & r_pend & ~w_gnt_vec;
  assign w_accept   = w_stb_ok & ~w_drop_vec;

  always_comb begin
    w_drop_n = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_drop_n = w_drop_n + 5'(w_drop_vec[k]);
    end
    w_drop_base = i_drop_clr ? '0 : r_drop_cnt;
    w_drop_sum  = (DROP_W+1)'(w_drop_base) + (DROP_W+1)'(w_drop_n);
    w_drop_next = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pend     <= (r_pend & ~w_gnt_vec) | w_accept;
      r_drop_cnt <= w_drop_next;
      if (w_grant) r_rr_ptr <= w_rr_next;
    end
  end

  // Hold contents are only meaningful while pending, so they need no reset.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_accept[k]) r_hold[k] <= i_ch_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef SOI_TIMESTAMP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ts <= '0;
    else          r_ts <= r_ts + TS_W'(1);
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_accept[k]) r_ts_hold[k] <= r_ts;
    end
  end
`endif

  always_comb begin
    w_push_word                       = '0;
    w_push_word[CH_W+DATA_W-1:0]      = {w_gnt_ch, r_hold[w_gnt_ch]};
`ifdef SOI_TIMESTAMP_EN
    w_push_word[REC_W-1 -: TS_W]      = r_ts_hold[w_gnt_ch];
`endif
  end

  soi_rec_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_grant),
    .i_wdata (w_push_word),
    .i_pop   (w_pop),
    .o_rdata (w_head_word),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  assign o_rec_valid = ~w_empty;
  assign o_rec_data  = w_head_word[DATA_W-1:0];
  assign o_rec_ch    = w_head_word[CH_W+DATA_W-1:DATA_W];
`ifdef SOI_TIMESTAMP_EN
  assign o_rec_ts    = w_head_word[REC_W-1 -: TS_W];
`endif
  assign o_drop_cnt  = r_drop_cnt;

endmodule
